// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the UART command parser: opcodes, parser states and
// small decode helpers.
package gpu_cmd_pkg;

   localparam logic [7:0] OP_SET_ADDR = 8'h01;
   localparam logic [7:0] OP_WRITE    = 8'h02;
   localparam logic [7:0] OP_FILL     = 8'h03;

   // A length byte of 0x00 encodes a full 256-transfer run.
   localparam bit LEN_ZERO_IS_256 = 1'b1;

   typedef enum logic [2:0] {
      S_OPCODE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_LEN,
      S_DATA,
      S_WR,
      S_FILL_VAL,
      S_FILL
   } parser_state_t;

   function automatic logic [8:0] len_to_count(input logic [7:0] len);
      if (LEN_ZERO_IS_256 && (len == 8'h00)) return 9'd256;
      return {1'b0, len};
   endfunction

   function automatic logic is_accept_state(input parser_state_t s);
      return (s != S_WR) && (s != S_FILL);
   endfunction

   function automatic logic is_timed_state(input parser_state_t s);
      return (s != S_OPCODE) && (s != S_WR) && (s != S_FILL);
   endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled and
// flags expiry once the full window has elapsed without a clear.
module cmd_timeout #(
   parameter int unsigned TIMEOUT_CLKS = 40_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int unsigned CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CLKS - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= LOAD_VAL;
      end else if (i_enable && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_expire = i_enable && !i_clear && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes the UART byte stream into VRAM write transactions (set pointer,
// burst write, fill) with protocol-error reporting and inter-byte timeout.
module uart_cmd_parser
   import gpu_cmd_pkg::*;
#(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned TIMEOUT_CLKS = 40_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              rx_error,
   output logic              rx_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              busy,
   output logic              proto_err
);

   parser_state_t     r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [8:0]        r_count;
   logic [7:0]        r_addr_hi;
   logic              r_is_fill;
   logic              r_holdoff;

   parser_state_t     w_state_n;
   logic [ADDR_W-1:0] w_ptr_n;
   logic [8:0]        w_count_n;
   logic [7:0]        w_addr_hi_n;
   logic              w_is_fill_n;
   logic [ADDR_W-1:0] w_addr_n;
   logic [7:0]        w_data_n;
   logic              w_we_n;
   logic              w_perr_n;

   logic              w_accept;
   logic              w_bad_byte;
   logic              w_timed;
   logic              w_expire;
   logic [ADDR_W-1:0] w_ptr_inc;

   // rx_ready is still high during the holdoff cycle after an ack.
   assign w_accept   = rx_ready && !r_holdoff && is_accept_state(r_state);
   assign w_bad_byte = w_accept && rx_error;
   assign w_timed    = is_timed_state(r_state);
   assign w_ptr_inc  = r_ptr + ADDR_W'(1);

   cmd_timeout #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_accept || !w_timed),
      .i_enable(w_timed),
      .o_expire(w_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_OPCODE;
         r_ptr     <= '0;
         r_count   <= '0;
         r_addr_hi <= '0;
         r_is_fill <= 1'b0;
         r_holdoff <= 1'b0;
         rx_ack    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_ptr     <= w_ptr_n;
         r_count   <= w_count_n;
         r_addr_hi <= w_addr_hi_n;
         r_is_fill <= w_is_fill_n;
         r_holdoff <= w_accept;
         rx_ack    <= w_accept;
         mem_addr  <= w_addr_n;
         mem_data  <= w_data_n;
         mem_we    <= w_we_n;
         busy      <= (w_state_n != S_OPCODE);
         proto_err <= w_perr_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_ptr_n     = r_ptr;
      w_count_n   = r_count;
      w_addr_hi_n = r_addr_hi;
      w_is_fill_n = r_is_fill;
      w_addr_n    = mem_addr;
      w_data_n    = mem_data;
      w_we_n      = mem_we;
      w_perr_n    = 1'b0;

      if (w_bad_byte) begin
         w_perr_n  = 1'b1;
         w_state_n = S_OPCODE;
      end else if (w_expire) begin
         w_perr_n  = 1'b1;
         w_state_n = S_OPCODE;
      end else begin
         case (r_state)
            S_OPCODE: begin
               if (w_accept) begin
                  case (rx_data)
                     OP_SET_ADDR: w_state_n = S_ADDR_HI;
                     OP_WRITE: begin
                        w_is_fill_n = 1'b0;
                        w_state_n   = S_LEN;
                     end
                     OP_FILL: begin
                        w_is_fill_n = 1'b1;
                        w_state_n   = S_LEN;
                     end
                     default: w_perr_n = 1'b1;
                  endcase
               end
            end
            S_ADDR_HI: begin
               if (w_accept) begin
                  w_addr_hi_n = rx_data;
                  w_state_n   = S_ADDR_LO;
               end
            end
            S_ADDR_LO: begin
               if (w_accept) begin
                  w_ptr_n   = ADDR_W'({r_addr_hi, rx_data});
                  w_state_n = S_OPCODE;
               end
            end
            S_LEN: begin
               if (w_accept) begin
                  w_count_n = len_to_count(rx_data);
                  w_state_n = r_is_fill ? S_FILL_VAL : S_DATA;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  w_addr_n  = r_ptr;
                  w_data_n  = rx_data;
                  w_we_n    = 1'b1;
                  w_state_n = S_WR;
               end
            end
            S_WR: begin
               if (mem_ready) begin
                  w_we_n    = 1'b0;
                  w_ptr_n   = w_ptr_inc;
                  w_count_n = r_count - 9'd1;
                  w_state_n = (r_count == 9'd1) ? S_OPCODE : S_DATA;
               end
            end
            S_FILL_VAL: begin
               if (w_accept) begin
                  w_addr_n  = r_ptr;
                  w_data_n  = rx_data;
                  w_we_n    = 1'b1;
                  w_state_n = S_FILL;
               end
            end
            S_FILL: begin
               // Address advances with each accepted write so a held
               // mem_ready streams one write per clock.
               if (mem_ready) begin
                  w_ptr_n   = w_ptr_inc;
                  w_addr_n  = w_ptr_inc;
                  w_count_n = r_count - 9'd1;
                  if (r_count == 9'd1) begin
                     w_we_n    = 1'b0;
                     w_state_n = S_OPCODE;
                  end
               end
            end
            default: w_state_n = S_OPCODE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a packet-level reference model queues
// expected VRAM writes; a negedge monitor compares every accepted write.
module tb_uart_cmd_parser;

   localparam int unsigned TO = 64;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_ready = 1'b0;
   logic        rx_error = 1'b0;
   logic        rx_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_we;
   logic        mem_ready = 1'b0;
   logic        busy;
   logic        proto_err;

   int n_tests = 0;
   int n_fail = 0;
   int ack_cnt = 0;
   int bytes_sent = 0;
   int perr_cnt = 0;
   int we_run = 0;
   int we_run_max = 0;
   int rdy_mode = 1;
   int gap_max = 0;
   logic [15:0] ptr_m = '0;
   wr_t exp_q[$];

   uart_cmd_parser #(
      .ADDR_W(16),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error), .rx_ack(rx_ack),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
      .busy(busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // VRAM side: mem_ready policy changes just after each rising edge.
   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0: mem_ready = 1'b0;
         1: mem_ready = 1'b1;
         default: mem_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: a write is taken at the rising edge following a negedge
   // where mem_we and mem_ready are both high.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_ack) ack_cnt++;
         if (proto_err) perr_cnt++;
         if (mem_we) we_run++;
         else begin
            if (we_run > we_run_max) we_run_max = we_run;
            we_run = 0;
         end
         if (mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                        mem_addr, mem_data);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", {16'h0, mem_addr}, {16'h0, e.addr});
               chk("wr_data", {24'h0, mem_data}, {24'h0, e.data});
            end
         end
      end
   end

   // Receiver model: holds data_ready until it sees ack, drops it one edge later.
   task automatic send_byte(input logic [7:0] b, input logic err);
      bit got;
      if (gap_max > 0) begin
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
      rx_data  = b;
      rx_error = err;
      rx_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         if (rx_ack) begin got = 1; break; end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL ack_timeout: got no ack for byte 0x%0h, expected ack", b);
         rx_ready = 1'b0;
         rx_error = 1'b0;
         return;
      end
      @(posedge clk); #1;
      rx_ready = 1'b0;
      rx_error = 1'b0;
      bytes_sent++;
      chk("ack_single_cycle", {31'h0, rx_ack}, 32'h0);
   endtask

   task automatic m_push(input logic [7:0] d);
      exp_q.push_back('{addr: ptr_m, data: d});
      ptr_m = ptr_m + 16'd1;
   endtask

   task automatic pkt_set(input logic [15:0] a);
      ptr_m = a;
      send_byte(8'h01, 1'b0);
      send_byte(a[15:8], 1'b0);
      send_byte(a[7:0], 1'b0);
   endtask

   task automatic pkt_write_rand(input int n);
      logic [7:0] d;
      send_byte(8'h02, 1'b0);
      send_byte(8'(n), 1'b0);
      for (int i = 0; i < n; i++) begin
         d = 8'($urandom);
         m_push(d);
         send_byte(d, 1'b0);
      end
   endtask

   task automatic pkt_fill(input logic [7:0] len, input logic [7:0] v);
      int n;
      n = (len == 8'h00) ? 256 : int'(len);
      for (int i = 0; i < n; i++) m_push(v);
      send_byte(8'h03, 1'b0);
      send_byte(len, 1'b0);
      send_byte(v, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk); #1;
         if (!busy && (exp_q.size() == 0)) break;
      end
      repeat (2) begin @(posedge clk); #1; end
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_idle"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0, p0, cyc;
      logic [15:0] hold_addr;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_ack", {31'h0, rx_ack}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_mem_data", {24'h0, mem_data}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_proto_err", {31'h0, proto_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Set pointer then burst three bytes.
      rdy_mode = 1;
      a0 = ack_cnt;
      pkt_set(16'h1234);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      m_push(8'hAA); send_byte(8'hAA, 1'b0);
      m_push(8'hBB); send_byte(8'hBB, 1'b0);
      m_push(8'hCC); send_byte(8'hCC, 1'b0);
      wait_idle("burst3");
      chk("burst3_ack_count", ack_cnt - a0, 8);

      // Fill 256 across the pointer wrap.
      pkt_set(16'hFFFF);
      we_run = 0;
      we_run_max = 0;
      pkt_fill(8'h00, 8'h5A);
      wait_idle("fill256");
      chk("fill256_we_run", we_run_max, 256);
      chk("fill256_ptr_wrap", {16'h0, ptr_m}, 32'h00FF);

      // Backpressure: write must hold stable while mem_ready is low.
      rdy_mode = 0;
      hold_addr = ptr_m;
      m_push(8'h77);
      send_byte(8'h02, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h77, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("stall_hold", {7'h0, mem_we, mem_addr, mem_data}, {7'h0, 1'b1, hold_addr, 8'h77});
         @(posedge clk); #1;
      end
      rdy_mode = 1;
      wait_idle("stall");

      // Inter-byte timeout inside a WRITE packet.
      p0 = perr_cnt;
      send_byte(8'h02, 1'b0);
      send_byte(8'h05, 1'b0);
      m_push(8'h11);
      send_byte(8'h11, 1'b0);
      cyc = 0;
      for (int i = 1; i <= int'(TO) + 20; i++) begin
         @(posedge clk); #1;
         if (proto_err) begin cyc = i; break; end
      end
      chk("timeout_latency_in_window",
          {31'h0, (cyc >= int'(TO) - 2) && (cyc <= int'(TO) + 2)}, 32'h1);
      chk("timeout_busy", {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
      chk("timeout_perr_count", perr_cnt - p0, 1);
      pkt_set(16'h0010);
      pkt_write_rand(1);
      wait_idle("after_timeout");

      // Unknown opcode.
      p0 = perr_cnt;
      send_byte(8'h7E, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      chk("badop_perr_count", perr_cnt - p0, 1);
      chk("badop_busy", {31'h0, busy}, 32'h0);

      // Receiver error flag on the second data byte aborts the packet.
      p0 = perr_cnt;
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      m_push(8'hA1);
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b1);
      wait_idle("rxerr");
      chk("rxerr_perr_count", perr_cnt - p0, 1);
      pkt_write_rand(2);
      wait_idle("after_rxerr");

      // Randomized packets with random backpressure and byte gaps.
      rdy_mode = 2;
      gap_max = 3;
      for (int p = 0; p < 24; p++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2) pkt_set(16'($urandom));
         else if (r < 7) pkt_write_rand($urandom_range(1, 6));
         else if (r < 9) pkt_fill(8'($urandom_range(1, 12)), 8'($urandom));
         else pkt_fill(8'h00, 8'($urandom));
      end
      wait_idle("random");
      gap_max = 0;

      // Asynchronous reset while a fill is stalled.
      rdy_mode = 0;
      pkt_fill(8'h04, 8'h99);
      for (int k = 0; k < 50; k++) begin
         if (mem_we) break;
         @(posedge clk); #1;
      end
      chk("prereset_we", {31'h0, mem_we}, 32'h1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("async_rst_we", {31'h0, mem_we}, 32'h0);
      chk("async_rst_busy", {31'h0, busy}, 32'h0);
      exp_q.delete();
      ptr_m = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rdy_mode = 1;
      @(posedge clk); #1;
      pkt_write_rand(2);
      wait_idle("post_reset");

      chk("ack_total", ack_cnt, bytes_sent);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
